// File: rtl/uart_host_bridge.sv
// Buffered host-side bridge to a uart_transceiver: TX FIFO feeding a write/done FSM, optional RX FIFO.
// Define UART_BRIDGE_RX_EN to build the RX FIFO and rx_ovf_o; otherwise the RX outputs are tied to 0.
module uart_host_bridge #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TX_GAP = 0
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_n_i,
  input  logic [DATA_W-1:0]      tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic [$clog2(DEPTH):0] tx_level_o,
  output logic [DATA_W-1:0]      utx_data_o,
  output logic                   utx_wr_o,
  input  logic                   utx_done_i,
  input  logic [DATA_W-1:0]      urx_data_i,
  input  logic                   urx_done_i,
  output logic [DATA_W-1:0]      rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic                   tx_ovf_o,
  output logic                   rx_ovf_o,
  input  logic                   clr_ovf_i
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned GAP_LAST = (TX_GAP > 0) ? TX_GAP - 1 : 0;
  localparam int unsigned GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [AW:0]       tx_wptr_q, tx_rptr_q;
  logic              tx_started_q;
  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic [1:0]        state_q, state_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] utx_data_q;
  logic              utx_wr_q, tx_ovf_q;

  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  // Ready only from registered state; tx_started_q holds it low until the first edge after reset.
  assign tx_ready_o = tx_started_q & ~tx_full;
  assign tx_push    = tx_valid_i & tx_ready_o;
  assign tx_pop     = (state_q == StIdle) & ~tx_empty;
  assign tx_level_o = tx_wptr_q - tx_rptr_q;
  assign utx_data_o = utx_data_q;
  assign utx_wr_o   = utx_wr_q;
  assign tx_ovf_o   = tx_ovf_q;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!tx_empty) state_d = StWait;
      end
      StWait: begin
        if (utx_done_i) begin
          if (TX_GAP > 0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GW'(GAP_LAST)) state_d = StIdle;
        else gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      tx_started_q <= 1'b0;
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      state_q      <= StIdle;
      gap_cnt_q    <= '0;
      utx_data_q   <= '0;
      utx_wr_q     <= 1'b0;
      tx_ovf_q     <= 1'b0;
    end else begin
      tx_started_q <= 1'b1;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      utx_wr_q     <= tx_pop;
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop) begin
        tx_rptr_q  <= tx_rptr_q + 1'b1;
        utx_data_q <= tx_mem[tx_rptr_q[AW-1:0]];
      end
      if (clr_ovf_i) tx_ovf_q <= 1'b0;
      else if (tx_valid_i && tx_full) tx_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= tx_data_i;
  end

`ifdef UART_BRIDGE_RX_EN
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW:0]       rx_wptr_q, rx_rptr_q;
  logic              rx_full, rx_empty, rx_push, rx_pop, rx_ovf_q;

  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_pop   = ~rx_empty & rx_ready_i;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign rx_push  = urx_done_i & (~rx_full | rx_pop);

  assign rx_valid_o = ~rx_empty;
  assign rx_data_o  = rx_empty ? '0 : rx_mem[rx_rptr_q[AW-1:0]];
  assign rx_ovf_o   = rx_ovf_q;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_ovf_q  <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop) rx_rptr_q <= rx_rptr_q + 1'b1;
      if (clr_ovf_i) rx_ovf_q <= 1'b0;
      else if (urx_done_i && !rx_push) rx_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= urx_data_i;
  end
`else
  logic rx_unused;
  assign rx_unused  = ^{urx_data_i, urx_done_i, rx_ready_i};
  assign rx_data_o  = '0;
  assign rx_valid_o = 1'b0;
  assign rx_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// Bench for uart_host_bridge: two instances (16-deep/no gap and 4-deep/gap 3) checked every cycle
// against a queue-based transaction model, plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_host_bridge;
  localparam int NI = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] tx_data [NI];
  logic          tx_valid [NI];
  logic          tx_ready [NI];
  logic [DW-1:0] utx_data [NI];
  logic          utx_wr [NI];
  logic          utx_done [NI];
  logic [DW-1:0] urx_data [NI];
  logic          urx_done [NI];
  logic [DW-1:0] rx_data [NI];
  logic          rx_valid [NI];
  logic          rx_ready [NI];
  logic          tx_ovf [NI];
  logic          rx_ovf [NI];
  logic          clr_ovf [NI];
  logic [4:0]    lvl_a;
  logic [2:0]    lvl_b;

  uart_host_bridge #(.DATA_W(DW), .DEPTH(16), .TX_GAP(0)) u_dut_a (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n),
    .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]),
    .tx_level_o(lvl_a), .utx_data_o(utx_data[0]), .utx_wr_o(utx_wr[0]),
    .utx_done_i(utx_done[0]), .urx_data_i(urx_data[0]), .urx_done_i(urx_done[0]),
    .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]), .rx_ready_i(rx_ready[0]),
    .tx_ovf_o(tx_ovf[0]), .rx_ovf_o(rx_ovf[0]), .clr_ovf_i(clr_ovf[0])
  );

  uart_host_bridge #(.DATA_W(DW), .DEPTH(4), .TX_GAP(3)) u_dut_b (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n),
    .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]),
    .tx_level_o(lvl_b), .utx_data_o(utx_data[1]), .utx_wr_o(utx_wr[1]),
    .utx_done_i(utx_done[1]), .urx_data_i(urx_data[1]), .urx_done_i(urx_done[1]),
    .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]), .rx_ready_i(rx_ready[1]),
    .tx_ovf_o(tx_ovf[1]), .rx_ovf_o(rx_ovf[1]), .clr_ovf_i(clr_ovf[1])
  );

  function automatic int unsigned depth_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] level_of(input int i);
    return (i == 0) ? 32'(lvl_a) : 32'(lvl_b);
  endfunction

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h (cycle %0d)", name, idx, act, exp, cyc);
  endtask

  // Transaction model: queues for the FIFOs, a busy flag and an earliest-next-write cycle for TX.
  bit [DW-1:0] m_txq [NI][$];
  bit [DW-1:0] m_rxq [NI][$];
  bit          m_started [NI];
  bit          m_busy [NI];
  bit          m_wr [NI];
  bit          m_tx_ovf [NI];
  bit          m_rx_ovf [NI];
  bit [DW-1:0] m_udata [NI];
  int          m_next_ok [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_txq[i].delete();
        m_rxq[i].delete();
        m_started[i] = 1'b0;
        m_busy[i] = 1'b0;
        m_wr[i] = 1'b0;
        m_tx_ovf[i] = 1'b0;
        m_rx_ovf[i] = 1'b0;
        m_udata[i] = '0;
        m_next_ok[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        bit push, pop;
`ifdef UART_BRIDGE_RX_EN
        bit rpop, rpush;
`endif
        push = tx_valid[i] && m_started[i] && (m_txq[i].size() < depth_of(i));
        pop  = !m_busy[i] && (cyc >= m_next_ok[i]) && (m_txq[i].size() > 0);
        if (clr_ovf[i]) m_tx_ovf[i] = 1'b0;
        else if (tx_valid[i] && m_txq[i].size() == depth_of(i)) m_tx_ovf[i] = 1'b1;
        if (m_busy[i] && utx_done[i]) begin
          m_busy[i] = 1'b0;
          m_next_ok[i] = cyc + gap_of(i) + 1;
        end
        m_wr[i] = pop;
        if (pop) begin
          m_udata[i] = m_txq[i].pop_front();
          m_busy[i] = 1'b1;
        end
        if (push) m_txq[i].push_back(tx_data[i]);
        m_started[i] = 1'b1;
`ifdef UART_BRIDGE_RX_EN
        rpop  = (m_rxq[i].size() > 0) && rx_ready[i];
        rpush = urx_done[i] && ((m_rxq[i].size() < depth_of(i)) || rpop);
        if (rpop) void'(m_rxq[i].pop_front());
        if (rpush) m_rxq[i].push_back(urx_data[i]);
        if (clr_ovf[i]) m_rx_ovf[i] = 1'b0;
        else if (urx_done[i] && !rpush) m_rx_ovf[i] = 1'b1;
`endif
      end
    end
  end

  // Observed write pulses and done-to-write spacing, used by the directed checks.
  logic [DW-1:0] wr_log [NI][$];
  int            last_done [NI];
  int            gap_meas [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit [DW-1:0] exp_rxd;
      exp_rxd = (m_rxq[i].size() > 0) ? m_rxq[i][0] : '0;
      if (rst_n && utx_done[i]) last_done[i] = cyc;
      if (rst_n && utx_wr[i]) begin
        wr_log[i].push_back(utx_data[i]);
        if (last_done[i] >= 0) gap_meas[i] = cyc - last_done[i] - 1;
      end
      check("tx_ready", i, 32'(tx_ready[i]),
            32'(m_started[i] && (m_txq[i].size() < depth_of(i))));
      check("tx_level", i, level_of(i), 32'(m_txq[i].size()));
      check("utx_wr", i, 32'(utx_wr[i]), 32'(m_wr[i]));
      check("utx_data", i, 32'(utx_data[i]), 32'(m_udata[i]));
      check("tx_ovf", i, 32'(tx_ovf[i]), 32'(m_tx_ovf[i]));
      check("rx_valid", i, 32'(rx_valid[i]), 32'(m_rxq[i].size() > 0));
      check("rx_data", i, 32'(rx_data[i]), 32'(exp_rxd));
      check("rx_ovf", i, 32'(rx_ovf[i]), 32'(m_rx_ovf[i]));
    end
  end

  // Transceiver stand-in: done a fixed delay after each write, plus one-shot stray pulses.
  bit resp_en [NI];
  int resp_delay [NI];
  int resp_cnt [NI];
  int stray_req [NI];
  int stray_ack [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      utx_done[i] = 1'b0;
      resp_cnt[i] = -1;
      stray_ack[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        utx_done[i] = 1'b0;
        if (!rst_n) begin
          resp_cnt[i] = -1;
        end else if (stray_req[i] != stray_ack[i]) begin
          utx_done[i] = 1'b1;
          stray_ack[i] = stray_req[i];
        end else if (resp_en[i]) begin
          if (utx_wr[i]) begin
            resp_cnt[i] = resp_delay[i] - 1;
          end else if (resp_cnt[i] == 0) begin
            utx_done[i] = 1'b1;
            resp_cnt[i] = -1;
          end else if (resp_cnt[i] > 0) begin
            resp_cnt[i]--;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [DW-1:0] d);
    tx_valid[i] = 1'b1;
    tx_data[i] = d;
    tick();
    tx_valid[i] = 1'b0;
  endtask

  task automatic wait_wr(input int i, input int n, input int bound);
    int k;
    k = 0;
    while (wr_log[i].size() < n && k < bound) begin
      tick();
      k++;
    end
    check("wr_count", i, 32'(wr_log[i].size()), 32'(n));
  endtask

  initial begin
    logic [DW-1:0] got [$];
    int base;
    for (int i = 0; i < NI; i++) begin
      tx_data[i] = '0;
      tx_valid[i] = 1'b0;
      urx_data[i] = '0;
      urx_done[i] = 1'b0;
      rx_ready[i] = 1'b0;
      clr_ovf[i] = 1'b0;
      resp_en[i] = 1'b0;
      resp_delay[i] = 20;
      stray_req[i] = 0;
      last_done[i] = -1;
      gap_meas[i] = -1;
    end

    // Reset values, then ready one edge after release.
    repeat (5) tick();
    check("rst_ready", 0, 32'(tx_ready[0]), 32'd0);
    check("rst_wr", 1, 32'(utx_wr[1]), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", 0, 32'(tx_ready[0]), 32'd1);
    check("rel_level", 1, level_of(1), 32'd0);

    // Burst of three bytes while the transceiver is busy.
    resp_en[0] = 1'b1;
    send(0, 8'h41);
    send(0, 8'h42);
    send(0, 8'h43);
    wait_wr(0, 3, 200);
    repeat (30) tick();
    check("burst_count", 0, 32'(wr_log[0].size()), 32'd3);
    got = wr_log[0];
    for (int k = 0; k < 3 && k < got.size(); k++)
      check("burst_byte", 0, 32'(got[k]), 32'h41 + 32'(k));
    check("burst_ovf", 0, 32'(tx_ovf[0]), 32'd0);
    check("burst_spacing", 0, 32'(gap_meas[0]), 32'd1);

    // Overflow on the 4-deep instance with done stalled: 1 in flight + 4 queued.
    for (int k = 0; k < 6; k++) begin
      tx_valid[1] = 1'b1;
      tx_data[1] = 8'h10 + 8'(k);
      tick();
    end
    tx_valid[1] = 1'b0;
    tick();
    check("ovf_level", 1, level_of(1), 32'd4);
    check("ovf_ready", 1, 32'(tx_ready[1]), 32'd0);
    check("ovf_flag", 1, 32'(tx_ovf[1]), 32'd1);
    check("ovf_inflight", 1, 32'(wr_log[1].size()), 32'd1);
    clr_ovf[1] = 1'b1;
    tick();
    clr_ovf[1] = 1'b0;
    check("ovf_clear", 1, 32'(tx_ovf[1]), 32'd0);

    // Drain with TX_GAP=3: four cycles from the cycle after done to the next write.
    resp_delay[1] = 2;
    resp_en[1] = 1'b1;
    stray_req[1]++;
    wait_wr(1, 5, 200);
    got = wr_log[1];
    for (int k = 0; k < 5 && k < got.size(); k++)
      check("drain_byte", 1, 32'(got[k]), 32'h10 + 32'(k));
    check("gap_spacing", 1, 32'(gap_meas[1]), 32'd4);

    // RX capture: 17 bytes into 16 entries with no consumer.
    for (int k = 0; k < 17; k++) begin
      urx_done[0] = 1'b1;
      urx_data[0] = 8'(k);
      tick();
    end
    urx_done[0] = 1'b0;
    tick();
`ifdef UART_BRIDGE_RX_EN
    check("rx_ovf_set", 0, 32'(rx_ovf[0]), 32'd1);
    rx_ready[0] = 1'b1;
    got.delete();
    for (int n = 0; n < 40 && got.size() < 16; n++) begin
      if (rx_valid[0]) got.push_back(rx_data[0]);
      tick();
    end
    rx_ready[0] = 1'b0;
    check("rx_drain_count", 0, 32'(got.size()), 32'd16);
    for (int k = 0; k < 16 && k < got.size(); k++)
      check("rx_drain_byte", 0, 32'(got[k]), 32'(k));
    clr_ovf[0] = 1'b1;
    tick();
    clr_ovf[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      urx_done[0] = 1'b1;
      urx_data[0] = 8'h20 + 8'(k);
      tick();
    end
    urx_data[0] = 8'h30;
    rx_ready[0] = 1'b1;
    tick();
    urx_done[0] = 1'b0;
    rx_ready[0] = 1'b0;
    check("rx_full_pop_ovf", 0, 32'(rx_ovf[0]), 32'd0);
    check("rx_full_pop_head", 0, 32'(rx_data[0]), 32'h21);
    rx_ready[0] = 1'b1;
    got.delete();
    for (int n = 0; n < 40 && got.size() < 16; n++) begin
      if (rx_valid[0]) got.push_back(rx_data[0]);
      tick();
    end
    rx_ready[0] = 1'b0;
    check("rx_tail_count", 0, 32'(got.size()), 32'd16);
    if (got.size() == 16) check("rx_tail_last", 0, 32'(got[15]), 32'h30);
`else
    check("rx_off_valid", 0, 32'(rx_valid[0]), 32'd0);
    check("rx_off_ovf", 0, 32'(rx_ovf[0]), 32'd0);
`endif

    // Reset while waiting on done with three bytes queued.
    resp_en[0] = 1'b0;
    base = wr_log[0].size();
    for (int k = 0; k < 4; k++) begin
      tx_valid[0] = 1'b1;
      tx_data[0] = 8'h61 + 8'(k);
      tick();
    end
    tx_valid[0] = 1'b0;
    repeat (3) tick();
    check("wait_level", 0, level_of(0), 32'd3);
    check("wait_inflight", 0, 32'(wr_log[0].size()), 32'(base + 1));
    rst_n = 1'b0;
    #1;
    check("async_level", 0, level_of(0), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    base = wr_log[0].size();
    stray_req[0]++;
    repeat (10) tick();
    check("stale_no_wr", 0, 32'(wr_log[0].size()), 32'(base));
    check("stale_level", 0, level_of(0), 32'd0);
    resp_en[0] = 1'b1;
    send(0, 8'h99);
    wait_wr(0, base + 1, 20);
    got = wr_log[0];
    if (got.size() > 0) check("post_rst_byte", 0, 32'(got[got.size()-1]), 32'h99);
    repeat (30) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_host_bridge.md
# uart_host_bridge

Parametrised, buffered host-side bridge between a bench or host byte stream and a `uart_transceiver` instance.
- A TX FIFO absorbs back-to-back host writes and serialises them into the transceiver's `tx_wr`/`tx_done` handshake, so bytes arriving while the transceiver is busy are held rather than dropped.
- An optional RX FIFO captures every `rx_done` byte for ready/valid consumption.
- Sticky overflow flags report lost data.

## Interface
- `DATA_W`, default 8: byte width on all data ports.
- `DEPTH`, default 16: entries per FIFO; must be a power of two and ≥ 2.
- `TX_GAP`, default 0: idle cycles inserted after each `utx_done_i` before the next `utx_wr_o`.
- `sys_clk_i`, in, 1: the only clock.
- `sys_rst_n_i`, in, 1: **asynchronous, active-low reset**.
- `tx_data_i`, in, `DATA_W`: host byte to send.
- `tx_valid_i`, in, 1: host write request.
- `tx_ready_o`, out, 1: TX FIFO not full.
- `tx_level_o`, out, `$clog2(DEPTH)+1`: TX FIFO occupancy.
- `utx_data_o`, out, `DATA_W`: byte to the transceiver's `tx_data`.
- `utx_wr_o`, out, 1: one-cycle write pulse to the transceiver.
- `utx_done_i`, in, 1: transceiver `tx_done`.
- `urx_data_i`, in, `DATA_W`: transceiver `rx_data`.
- `urx_done_i`, in, 1: transceiver `rx_done`.
- `rx_data_o`, out, `DATA_W`: RX FIFO head.
- `rx_valid_o`, out, 1: RX FIFO not empty.
- `rx_ready_i`, in, 1: consumer pops the head.
- `tx_ovf_o`, out, 1: sticky; a write was attempted while the TX FIFO was full.
- `rx_ovf_o`, out, 1: sticky; a received byte was dropped.
- `clr_ovf_i`, in, 1: clears both overflow flags.

## Operation
- **Reset.** While `sys_rst_n_i` is low, all outputs are 0, both FIFOs are empty, the FSM is in IDLE and `tx_ready_o` is 0. On release, `tx_ready_o` rises on the first edge.
- **TX push.** A push occurs on each edge where `tx_valid_i & tx_ready_o`.
  - `tx_valid_i` while full drops the byte and sets `tx_ovf_o`.
  - A pop in the same cycle does not make a full FIFO accept a write, because `tx_ready_o` is derived from the registered full state only.
- **TX FSM.**
  - IDLE: if the FIFO is non-empty, pop the head into `utx_data_o`, pulse `utx_wr_o` for exactly one cycle, then go to WAIT.
  - WAIT: hold `utx_data_o`. On `utx_done_i`, go to GAP if `TX_GAP > 0`, otherwise to IDLE.
  - GAP: count `TX_GAP` cycles, then go to IDLE.
  - `utx_done_i` outside WAIT is ignored.
- **RX capture.** `urx_done_i` pushes `urx_data_i` into the RX FIFO.
  - When the FIFO is full, the push is accepted only if `rx_valid_o & rx_ready_i` in the same cycle. Otherwise the byte is dropped and `rx_ovf_o` is set.
  - The FIFO is first-word-fall-through: `rx_data_o` shows the head whenever `rx_valid_o` is high.
- **Pointers.** Read and write pointers are `$clog2(DEPTH)+1` bits and wrap modulo `2*DEPTH`. Full means the MSBs differ and the remaining bits are equal; empty means the pointers are equal.
- **Overflow flags.** `clr_ovf_i` takes priority over a same-cycle set.

## Timing
- A byte accepted into an empty TX FIFO at edge N, with the FSM in IDLE, gives `utx_wr_o` high in the cycle following edge N+1. TX path latency is 2 edges.
- Minimum spacing between `utx_wr_o` pulses is the cycle of `utx_done_i`, plus `TX_GAP`, plus 1 IDLE cycle.
- An RX byte with `urx_done_i` at edge N makes `rx_valid_o` high after edge N. An RX pop takes effect at the same edge it is sampled.
- `tx_level_o` updates one edge after a push or pop. A simultaneous push and pop leaves it unchanged.
- Asserting reset mid-transfer aborts immediately.
  - `utx_wr_o` drops asynchronously and FIFO contents are discarded.
  - After release, the FSM ignores any stale `utx_done_i`, since the FSM is in IDLE.

## Configuration
- **`UART_BRIDGE_RX_EN`**
  - Defined: the RX FIFO and `rx_ovf_o` are implemented as above.
  - Undefined: no RX storage is built. `rx_data_o`, `rx_valid_o` and `rx_ovf_o` are tied to 0, and `urx_*` and `rx_ready_i` are ignored.

## Test plan
- **Reset values:** hold reset low 5 cycles → all outputs 0. Release → `tx_ready_o` = 1 after one edge, `tx_level_o` = 0.
- **Burst under back-pressure:** burst `0x41,0x42,0x43` on consecutive cycles; respond with `utx_done_i` 20 cycles after each `utx_wr_o` → exactly three `utx_wr_o` pulses carrying `0x41,0x42,0x43` in order, and `tx_ovf_o` stays 0.
- **TX overflow:** `DEPTH`=4, stall `utx_done_i`, write 6 bytes → 5 accepted (1 in flight plus 4 queued), `tx_ready_o` = 0, `tx_ovf_o` = 1. `clr_ovf_i` clears the flag.
- **Inter-byte gap:** `TX_GAP`=3 → exactly 4 cycles from the cycle after `utx_done_i` to the next `utx_wr_o`.
- **RX capture:** `rx_ready_i` = 0, 17 `urx_done_i` bytes `0x00..0x10` at `DEPTH`=16 → `rx_ovf_o` = 1. Draining yields `0x00..0x0F`. A push on a full FIFO with a simultaneous pop is accepted.
- **Reset during WAIT:** assert reset while the FSM is in WAIT with 3 bytes queued → after release, no `utx_wr_o` until a new write, and a stray `utx_done_i` is ignored.
